// File: rtl/spi_arb_pkg.sv
// -----------------------------------------------------------------------------
// spi_arb_pkg
// Shared definitions for the SPI arbiter: FSM state encoding and the frame
// returned to a requester when a transaction is abandoned on timeout.
// No ports (package).
// -----------------------------------------------------------------------------
package spi_arb_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_LOAD      = 3'd1;
  localparam state_t ST_START     = 3'd2;
  localparam state_t ST_WAIT_DONE = 3'd3;
  localparam state_t ST_RESP      = 3'd4;

  // Error response frame; sliced down to the configured frame width (<= 64).
  localparam logic [63:0] ERR_FRAME = '1;

endpackage

// File: rtl/spi_arbiter_rr_select.sv
// -----------------------------------------------------------------------------
// rr_select
// Combinational round-robin picker: returns the first set request bit found
// when searching upward from ptr, wrapping modulo NUM_REQ.
// Ports:
//   req        in   NUM_REQ          request vector
//   ptr        in   $clog2(NUM_REQ)  highest-priority index
//   grant      out  NUM_REQ          one-hot grant (all zero when no request)
//   grant_idx  out  $clog2(NUM_REQ)  index of the granted bit
//   any        out  1                at least one request is set
// -----------------------------------------------------------------------------
module rr_select #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       any
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic             found;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] pos;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    pos       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // One extra bit holds ptr+k before the modulo fold.
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      pos = sum[IDX_W-1:0];
      if (!found && req[pos]) begin
        found     = 1'b1;
        grant[pos] = 1'b1;
        grant_idx = pos;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/spi_arbiter.sv
// -----------------------------------------------------------------------------
// spi_arbiter
// Shares one SPI master between NUM_REQ requesters. Round-robin grant, then
// one complete SPI transaction per grant: load frame/CS, start, wait done,
// capture the MISO frame and return it to the granted requester.
//
// Optional feature macro: SPI_ARB_TIMEOUT_EN
//   defined   : START and WAIT_DONE are bounded by TIMEOUT_CYCLES; on expiry
//               the requester receives an all-ones frame with r_resp_err_out=1.
//   undefined : both phases wait indefinitely; r_resp_err_out is tied to 0.
//
// Handshakes: a requester holds req_valid_in with its frame and CS stable
// until it sees its r_req_ready_out pulse; data/CS are sampled only at the
// grant. r_resp_valid_out pulses one cycle to the same requester, qualifying
// r_resp_data_out and r_resp_err_out.
//
// Ports:
//   clk_in                 in   1                 clock, rising edge
//   reset_n_in             in   1                 async active-low reset
//   req_valid_in           in   NUM_REQ           pending request per requester
//   req_data_in            in   NUM_REQ*SIZE      frame i at [i*SIZE +: SIZE]
//   req_cs_in              in   NUM_REQ*CS_WIDTH  CS index i at [i*CS_WIDTH +: CS_WIDTH]
//   r_req_ready_out        out  NUM_REQ           accept pulse
//   r_resp_valid_out       out  NUM_REQ           response pulse
//   r_resp_data_out        out  SIZE              received frame (held)
//   r_resp_err_out         out  1                 timeout flag
//   r_spi_data_out         out  SIZE              to spi data_in
//   r_spi_cs_select_out    out  CS_WIDTH          to spi cs_select_in
//   r_spi_send_enable_out  out  1                 to spi send_enable_in
//   spi_ready_in           in   1                 spi idle/done
//   spi_data_in            in   SIZE              spi received frame
//   r_busy_out             out  1                 high outside IDLE
//   state_dbg              out  3                 current FSM state
// -----------------------------------------------------------------------------
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int SIZE           = 40,
  parameter int CS_WIDTH       = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                         clk_in,
  input  logic                         reset_n_in,
  input  logic [NUM_REQ-1:0]           req_valid_in,
  input  logic [NUM_REQ*SIZE-1:0]      req_data_in,
  input  logic [NUM_REQ*CS_WIDTH-1:0]  req_cs_in,
  output logic [NUM_REQ-1:0]           r_req_ready_out,
  output logic [NUM_REQ-1:0]           r_resp_valid_out,
  output logic [SIZE-1:0]              r_resp_data_out,
  output logic                         r_resp_err_out,
  output logic [SIZE-1:0]              r_spi_data_out,
  output logic [CS_WIDTH-1:0]          r_spi_cs_select_out,
  output logic                         r_spi_send_enable_out,
  input  logic                         spi_ready_in,
  input  logic [SIZE-1:0]              spi_data_in,
  output logic                         r_busy_out,
  output state_t                       state_dbg
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || SIZE > 64 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("spi_arbiter: parameter out of supported range");
  end

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [IDX_W-1:0]   gnt_idx;
  logic               saw_ready;
  logic               timed_out;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [SIZE-1:0]    sel_data;
  logic [CS_WIDTH-1:0] sel_cs;
  logic               start_done;
  logic               tmo_hit;

  rr_select #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_select (
    .req       (req_valid_in),
    .ptr       (ptr),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  // Frame/CS of the latched grant.
  always_comb begin
    sel_data = '0;
    sel_cs   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_oh[i]) begin
        sel_data = req_data_in[i*SIZE +: SIZE];
        sel_cs   = req_cs_in[i*CS_WIDTH +: CS_WIDTH];
      end
    end
  end

  // The spi has taken the frame only once ready was seen high during START
  // and has since dropped; a ready already low on entry is a previous,
  // unrelated busy period.
  assign start_done = saw_ready && !spi_ready_in;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES+1);

  logic [CNT_W-1:0] tmo_cnt;

  assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES));

  // Cleared on entry to START (from LOAD) and to WAIT_DONE (START exit).
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      tmo_cnt <= '0;
    end else if (state == ST_LOAD || (state == ST_START && start_done)) begin
      tmo_cnt <= '0;
    end else if ((state == ST_START || state == ST_WAIT_DONE) && !tmo_hit) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state                 <= ST_IDLE;
      ptr                   <= '0;
      gnt_oh                <= '0;
      gnt_idx               <= '0;
      saw_ready             <= 1'b0;
      timed_out             <= 1'b0;
      r_req_ready_out       <= '0;
      r_resp_valid_out      <= '0;
      r_resp_data_out       <= '0;
      r_spi_data_out        <= '0;
      r_spi_cs_select_out   <= '0;
      r_spi_send_enable_out <= 1'b0;
      r_busy_out            <= 1'b0;
    end else begin
      r_req_ready_out  <= '0;
      r_resp_valid_out <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            gnt_oh     <= pick_grant;
            gnt_idx    <= pick_idx;
            r_busy_out <= 1'b1;
            state      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_spi_data_out        <= sel_data;
          r_spi_cs_select_out   <= sel_cs;
          r_req_ready_out       <= gnt_oh;
          r_spi_send_enable_out <= 1'b1;
          saw_ready             <= 1'b0;
          timed_out             <= 1'b0;
          state                 <= ST_START;
        end
        ST_START: begin
          if (spi_ready_in) begin
            saw_ready <= 1'b1;
          end
          if (start_done) begin
            r_spi_send_enable_out <= 1'b0;
            state                 <= ST_WAIT_DONE;
          end else if (tmo_hit) begin
            r_spi_send_enable_out <= 1'b0;
            timed_out             <= 1'b1;
            state                 <= ST_RESP;
          end
        end
        ST_WAIT_DONE: begin
          r_spi_send_enable_out <= 1'b0;
          if (spi_ready_in) begin
            state <= ST_RESP;
          end else if (tmo_hit) begin
            timed_out <= 1'b1;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_resp_data_out  <= timed_out ? ERR_FRAME[SIZE-1:0] : spi_data_in;
          r_resp_valid_out <= gnt_oh;
          ptr              <= (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
          r_busy_out       <= 1'b0;
          state            <= ST_IDLE;
        end
        default: begin
          r_spi_send_enable_out <= 1'b0;
          r_busy_out            <= 1'b0;
          state                 <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_resp_err_out <= 1'b0;
    end else if (state == ST_RESP) begin
      r_resp_err_out <= timed_out;
    end
  end
`else
  assign r_resp_err_out = 1'b0;
`endif

  assign state_dbg = state;

endmodule

// File: tb/tb_spi_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_arbiter
// Bench for spi_arbiter with a behavioural spi model. Expected grants come
// from a round-robin search over the driven request vector; expected
// responses from the frame the model received, xor'd with miso_key.
// -----------------------------------------------------------------------------
module tb_spi_arbiter;
  import spi_arb_pkg::*;

  localparam int N   = 4;
  localparam int W   = 40;
  localparam int CSW = 4;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 4096;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [N-1:0]     req_valid = '0;
  logic [N*W-1:0]   req_data;
  logic [N*CSW-1:0] req_cs;
  logic [W-1:0]     v_data [N];
  logic [CSW-1:0]   v_cs   [N];
  logic [N-1:0]     r_req_ready_out;
  logic [N-1:0]     r_resp_valid_out;
  logic [W-1:0]     r_resp_data_out;
  logic             r_resp_err_out;
  logic [W-1:0]     r_spi_data_out;
  logic [CSW-1:0]   r_spi_cs_select_out;
  logic             r_spi_send_enable_out;
  logic             spi_ready;
  logic [W-1:0]     spi_miso;
  logic             r_busy_out;
  state_t           state_dbg;

  always_comb begin
    req_data = '0;
    req_cs   = '0;
    for (int i = 0; i < N; i++) begin
      req_data[i*W +: W]     = v_data[i];
      req_cs[i*CSW +: CSW]   = v_cs[i];
    end
  end

  spi_arbiter #(
    .NUM_REQ        (N),
    .SIZE           (W),
    .CS_WIDTH       (CSW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_in                (clk),
    .reset_n_in            (rst_n),
    .req_valid_in          (req_valid),
    .req_data_in           (req_data),
    .req_cs_in             (req_cs),
    .r_req_ready_out       (r_req_ready_out),
    .r_resp_valid_out      (r_resp_valid_out),
    .r_resp_data_out       (r_resp_data_out),
    .r_resp_err_out        (r_resp_err_out),
    .r_spi_data_out        (r_spi_data_out),
    .r_spi_cs_select_out   (r_spi_cs_select_out),
    .r_spi_send_enable_out (r_spi_send_enable_out),
    .spi_ready_in          (spi_ready),
    .spi_data_in           (spi_miso),
    .r_busy_out            (r_busy_out),
    .state_dbg             (state_dbg)
  );

  // ---------------- spi model ----------------
  logic [W-1:0] miso_key   = '0;
  logic [W-1:0] rx_frame   = '0;
  logic         spi_rdy_q  = 1'b1;
  logic         spi_stuck  = 1'b0;
  int           busy_len   = 5;
  int           busy_cnt   = 0;
  int           cyc        = 0;
  int           hold_until = 0;
  int           spi_starts = 0;

  assign spi_ready = spi_rdy_q && (cyc >= hold_until);
  assign spi_miso  = rx_frame ^ miso_key;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (busy_cnt > 0) begin
      if (busy_cnt == 1) spi_rdy_q <= 1'b1;
      busy_cnt <= busy_cnt - 1;
    end else if (spi_rdy_q && cyc >= hold_until && r_spi_send_enable_out && !spi_stuck) begin
      rx_frame   <= r_spi_data_out;
      spi_rdy_q  <= 1'b0;
      busy_cnt   <= busy_len;
      spi_starts <= spi_starts + 1;
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];
  int ptr_m = 0;
  logic [W-1:0] last_resp;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Protocol monitor: accepts and responses must alternate.
  int resp_count  = 0;
  bit outstanding = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      outstanding <= 1'b0;
    end else begin
      if (|r_req_ready_out) begin
        check("accept_without_resp", 64'(outstanding), 64'(0));
        outstanding <= 1'b1;
      end
      if (|r_resp_valid_out) begin
        outstanding <= 1'b0;
        resp_count  <= resp_count + 1;
      end
    end
  end

  // ---------------- reference model / driver ----------------
  function automatic int model_pick();
    for (int k = 0; k < N; k++) begin
      if (req_valid[(ptr_m + k) % N]) return (ptr_m + k) % N;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic raise(input int i);
    logic [63:0] tmp;
    tmp        = {$urandom(), $urandom()};
    v_data[i]  = tmp[W-1:0];
    v_cs[i]    = CSW'($urandom_range(0, 15));
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_accept(output int idx, output bit ok);
    ok = 1'b0; idx = -1;
    for (int c = 0; c < 2000 && !ok; c++) begin
      @(negedge clk);
      if (|r_req_ready_out) begin ok = 1'b1; idx = onehot_idx(r_req_ready_out); end
    end
  endtask

  task automatic wait_resp(output int idx, output bit ok);
    ok = 1'b0; idx = -1;
    for (int c = 0; c < 2000 && !ok; c++) begin
      @(negedge clk);
      if (|r_resp_valid_out) begin ok = 1'b1; idx = onehot_idx(r_resp_valid_out); end
    end
  endtask

  // Called at a negedge with the DUT in IDLE and the request vector set.
  task automatic run_txn(input bit keep_valid, input bit churn, input int hold,
                         input bit exp_err, output int g);
    int gi; bit ok; int s0; logic [W-1:0] exp_frame;
    s0 = spi_starts;
    g  = model_pick();
    if (g < 0) return;
    exp_q.push_back(exp_err ? {W{1'b1}} : (v_data[g] ^ miso_key));
    wait_accept(gi, ok);
    check("accept_seen", 64'(ok), 64'(1));
    if (ok) begin
      check("grant_idx", 64'(gi), 64'(g));
      check("accept_onehot", 64'(r_req_ready_out), 64'(1) << g);
      check("spi_data", 64'(r_spi_data_out), 64'(v_data[g]));
      check("spi_cs", 64'(r_spi_cs_select_out), 64'(v_cs[g]));
      check("send_en_with_frame", 64'(r_spi_send_enable_out), 64'(1));
      check("busy_in_txn", 64'(r_busy_out), 64'(1));
      if (hold > 0) begin
        hold_until = cyc + hold;
        s0 = spi_starts;
        repeat (hold - 2) @(negedge clk);
        check("hold_send_en", 64'(r_spi_send_enable_out), 64'(1));
        check("hold_no_start", 64'(spi_starts), 64'(s0));
      end
      if (keep_valid) raise(g);
      else req_valid[g] = 1'b0;
      if (churn) begin
        for (int i = 0; i < N; i++) begin
          if (i != g && $urandom_range(0, 3) == 0) begin
            if (req_valid[i]) req_valid[i] = 1'b0;
            else raise(i);
          end
        end
      end
    end
    wait_resp(gi, ok);
    check("resp_seen", 64'(ok), 64'(1));
    exp_frame = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    if (ok) begin
      check("resp_idx", 64'(gi), 64'(g));
      check("resp_data", 64'(r_resp_data_out), 64'(exp_frame));
      check("resp_err", 64'(r_resp_err_out), 64'(exp_err));
      check("send_en_low_at_resp", 64'(r_spi_send_enable_out), 64'(0));
      last_resp = r_resp_data_out;
      ptr_m = (g + 1) % N;
      if (hold > 0) check("one_spi_start", 64'(spi_starts), 64'(s0 + 1));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"},  64'(r_req_ready_out), 64'(0));
    check({tag, "_resp_v"}, 64'(r_resp_valid_out), 64'(0));
    check({tag, "_resp_d"}, 64'(r_resp_data_out), 64'(0));
    check({tag, "_err"},    64'(r_resp_err_out), 64'(0));
    check({tag, "_data"},   64'(r_spi_data_out), 64'(0));
    check({tag, "_cs"},     64'(r_spi_cs_select_out), 64'(0));
    check({tag, "_en"},     64'(r_spi_send_enable_out), 64'(0));
    check({tag, "_busy"},   64'(r_busy_out), 64'(0));
    check({tag, "_state"},  64'(state_dbg), 64'(ST_IDLE));
  endtask

  // ---------------- stimulus ----------------
  int order [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    int g; int gi; bit ok; int cnt0;
    for (int i = 0; i < N; i++) begin v_data[i] = '0; v_cs[i] = '0; end

    // Reset values.
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single request from requester 1.
    miso_key  = 40'h12_3456_789A ^ 40'hA5_0000_00FF;
    v_data[1] = 40'h12_3456_789A;
    v_cs[1]   = 4'd3;
    req_valid = 4'b0010;
    run_txn(1'b0, 1'b0, 0, 1'b0, g);
    check("single_grant", 64'(g), 64'(1));
    check("single_resp", 64'(last_resp), 64'h00A5_0000_00FF);

    // Pointer wrap: grant 2 puts the pointer at 3, then 1001 -> 3, 0.
    raise(2);
    run_txn(1'b0, 1'b0, 0, 1'b0, g);
    check("wrap_pre", 64'(g), 64'(2));
    raise(0); raise(3);
    run_txn(1'b0, 1'b0, 0, 1'b0, g);
    check("wrap_first", 64'(g), 64'(3));
    run_txn(1'b0, 1'b0, 0, 1'b0, g);
    check("wrap_second", 64'(g), 64'(0));
    raise(3);
    run_txn(1'b0, 1'b0, 0, 1'b0, g);

    // All four continuously requesting, long spi busy time.
    miso_key = 40'h0F_F0F0_5A5A;
    busy_len = 50;
    for (int i = 0; i < N; i++) raise(i);
    for (int k = 0; k < 6; k++) begin
      run_txn(1'b1, 1'b0, 0, 1'b0, g);
      check("rr_order", 64'(g), 64'(order[k]));
    end
    req_valid = '0;
    busy_len  = 5;

    // Spi still busy on entry to START.
    raise(0);
    run_txn(1'b0, 1'b0, 10, 1'b0, g);
    check("busy_start_grant", 64'(g), 64'(0));

    // Reset while in WAIT_DONE.
    busy_len = 20;
    raise(3);
    wait_accept(gi, ok);
    check("rst_txn_accept", 64'(gi), 64'(3));
    req_valid = '0;
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (state_dbg == ST_WAIT_DONE) ok = 1'b1;
    end
    check("reach_wait_done", 64'(ok), 64'(1));
    cnt0 = resp_count;
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    raise(1); raise(3);
    repeat (3) @(negedge clk);
    check("no_resp_in_reset", 64'(resp_count), 64'(cnt0));
    rst_n = 1'b1;
    ptr_m = 0;
    run_txn(1'b0, 1'b0, 0, 1'b0, g);
    check("grant_after_reset", 64'(g), 64'(1));
    run_txn(1'b0, 1'b0, 0, 1'b0, g);
    busy_len = 5;

    // Randomized traffic with request churn and withdrawal.
    miso_key = {$urandom(), 8'h3C};
    for (int t = 0; t < 30; t++) begin
      busy_len = $urandom_range(1, 8);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) raise(i);
      end
      if (req_valid == '0) raise($urandom_range(0, N-1));
      run_txn(1'($urandom_range(0, 1)), 1'b1, 0, 1'b0, g);
    end
    req_valid = '0;

`ifdef SPI_ARB_TIMEOUT_EN
    // Spi never accepts: transaction must time out with an error frame.
    @(negedge clk);
    spi_stuck = 1'b1;
    raise(2);
    run_txn(1'b0, 1'b0, 0, 1'b1, g);
    check("timeout_data", 64'(last_resp), 64'h00FF_FFFF_FFFF);
    spi_stuck = 1'b0;
    raise(1);
    run_txn(1'b0, 1'b0, 0, 1'b0, g);
`endif

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/spi_arbiter.md
Name: spi_arbiter

Overview:
- Shares the single 40-bit SPI master between NUM_REQ requesters (CPU register path, angle/step controllers, driver config sequencer).
- Per-requester valid/ready request handshake; round-robin grant.
- Sequences one complete SPI transaction per grant: load frame and CS, start, wait done, capture MISO frame, return response to the granted requester.
- Sits between requesters and the spi module; clocked on peripheral_clk.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SIZE, 40, SPI frame width in bits.
- CS_WIDTH, 4, CS select index width (matches spi cs_select_in).
- TIMEOUT_CYCLES, 4096, per-phase timeout limit in clk_in cycles (used only with SPI_ARB_TIMEOUT_EN).

Ports:
- clk_in  input  1  clock; all logic on the rising edge.
- reset_n_in  input  1  reset; asynchronous, active-low.
- req_valid_in  input  NUM_REQ  requester i has a frame pending; held until accepted.
- req_data_in  input  NUM_REQ*SIZE  frame of requester i at [i*SIZE +: SIZE].
- req_cs_in  input  NUM_REQ*CS_WIDTH  CS index of requester i.
- r_req_ready_out  output  NUM_REQ  one-cycle accept pulse to the granted requester.
- r_resp_valid_out  output  NUM_REQ  one-cycle response pulse to the granted requester.
- r_resp_data_out  output  SIZE  received frame, valid with the response pulse, held until the next response.
- r_resp_err_out  output  1  timeout flag, qualified by the response pulse.
- r_spi_data_out  output  SIZE  to spi data_in.
- r_spi_cs_select_out  output  CS_WIDTH  to spi cs_select_in.
- r_spi_send_enable_out  output  1  to spi send_enable_in.
- spi_ready_in  input  1  from spi r_ready_out; 1 = idle or done.
- spi_data_in  input  SIZE  from spi data_out.
- r_busy_out  output  1  high in every state except IDLE.

Behaviour:
- All outputs are registered. On reset every output is 0, state is IDLE and the priority pointer is 0. Reset may arrive in any state; send_enable drops immediately and the in-flight transaction is dropped with no response pulse.
- IDLE: if any req_valid_in is set, grant g = the first set bit searching from the pointer upward, wrapping modulo NUM_REQ. Go to LOAD.
- LOAD (1 cycle):
  - latch req_data_in[g] into r_spi_data_out and req_cs_in[g] into r_spi_cs_select_out;
  - pulse r_req_ready_out[g];
  - go to START.
- START: hold r_spi_send_enable_out=1 until spi_ready_in==0 (spi has accepted the frame), then go to WAIT_DONE.
- WAIT_DONE: r_spi_send_enable_out=0; wait for spi_ready_in==1, then go to RESP.
- RESP (1 cycle):
  - r_resp_data_out <= spi_data_in;
  - pulse r_resp_valid_out[g]; r_resp_err_out=0;
  - pointer <= (g+1) mod NUM_REQ;
  - go to IDLE.
- Minimum latency from req_valid_in rising (in IDLE) to the response pulse is 4 cycles plus the SPI busy time.
- The request is sampled only at the grant. Deasserting req_valid_in after the accept pulse has no effect on the transaction. Deasserting it before the grant withdraws the request.
- Requests arriving in non-IDLE states wait; there is no queuing beyond the req_valid_in level.
- A requester whose valid is still high after its response competes again, but only after all other pending requesters (round-robin fairness).
- Data, CS and send_enable are never changed while the spi module is busy; r_spi_data_out and r_spi_cs_select_out stay stable from LOAD through RESP.
- If spi_ready_in is already 0 on entry to START (spi still busy), START waits: it first requires spi_ready_in==1 and then a high-to-low transition. This uses a sawready flag.

Optional Feature:
- Macro: SPI_ARB_TIMEOUT_EN.
- Defined:
  - a counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to START and to WAIT_DONE;
  - if the counter reaches TIMEOUT_CYCLES before the exit condition, r_spi_send_enable_out goes to 0 and the block goes to RESP;
  - in RESP, r_resp_data_out is all ones and r_resp_err_out=1.
- Undefined: no counter; START and WAIT_DONE wait indefinitely; r_resp_err_out is tied to 0.

Decomposition:
- Package spi_arb_pkg:
  - state enum: IDLE, LOAD, START, WAIT_DONE, RESP;
  - localparam ERR_FRAME (all ones).
- Sub-module rr_select: combinational round-robin picker. Inputs: request vector and pointer. Outputs: one-hot grant and grant index. Unit-testable alone.

Test Plan:
- Single request: req_valid_in=4'b0010, req_data_in[1]=40'h12_3456_789A, cs=3. Required response: r_req_ready_out[1] pulses once; r_spi_cs_select_out=3 and r_spi_data_out=40'h12_3456_789A before send_enable; r_resp_valid_out[1] pulses once with r_resp_data_out equal to the model's MISO frame 40'hA5_0000_00FF.
- All four requesting continuously, spi model with 50-cycle busy time. Required grant order: 0,1,2,3,0,1. No two accept pulses without an intervening response pulse.
- Pointer wrap: pointer=3, requests 4'b1001. Required grant: 3, then 0.
- Spi already busy at START (spi_ready_in=0 for 10 cycles after LOAD). Required response: send_enable held; the transaction starts only after ready rises and falls; one response pulse.
- Reset asserted in WAIT_DONE. Required response: all outputs 0 asynchronously; no response pulse; after release, a pending request is granted from pointer 0.
- SPI_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16 and spi_ready_in stuck at 1. Required response: after 16 cycles in START, r_resp_valid_out[g]=1 with r_resp_err_out=1 and data 40'hFF_FFFF_FFFF; send_enable=0; the next request is served normally.
